// File: rtl/bcd_decimal_scan_decoder.sv
// Multi-digit BCD to 1-of-10 decimal decoder with a time-multiplexed digit scan.
// A word is captured on a valid/ready handshake and then scanned from the least significant digit, with each digit held for DWELL cycles.
module bcd_decimal_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  in_lzb,
  output logic [9:0]            dec,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  err,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  typedef enum logic [0:0] {IDLE, SCAN} state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  shadow;
  logic [DIGITS-1:0]    blank_mask;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        cnt;

  logic                 accept;
  logic [DIGITS-1:0]    cap_mask;
  logic                 zero_above;
  logic [4*DIGITS-1:0]  src_word;
  logic [DIGITS-1:0]    src_mask;
  logic [IW-1:0]        src_idx;
  logic [3:0]           nib;
  logic [9:0]           nxt_dec;
  logic [DIGITS-1:0]    nxt_sel;
  logic                 nxt_err;

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;

  // A digit is blanked only while it and every digit above it are zero;
  // digit 0 is always shown, and an invalid nibble breaks the zero run.
  always_comb begin
    cap_mask   = '0;
    zero_above = in_lzb;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (in_bcd[4*i +: 4] == 4'd0);
      cap_mask[i] = zero_above;
    end
  end

  // On accept, digit 0 of the incoming word loads the outputs directly so it appears on the cycle after the handshake.
  always_comb begin
    src_word = accept ? in_bcd : shadow;
    src_mask = accept ? cap_mask : blank_mask;
    src_idx  = accept ? '0 : idx + IW'(1);
    nib      = 4'(src_word >> (4 * src_idx));
    nxt_err  = (nib > 4'd9);
    nxt_dec  = (!nxt_err && !src_mask[src_idx]) ? (10'(1) << nib) : '0;
    nxt_sel  = DIGITS'(1) << src_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      blank_mask <= '0;
      idx        <= '0;
      cnt        <= '0;
      dec        <= '0;
      dig_sel    <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= SCAN;
            shadow     <= in_bcd;
            blank_mask <= cap_mask;
            idx        <= '0;
            cnt        <= '0;
            dec        <= nxt_dec;
            dig_sel    <= nxt_sel;
            err        <= nxt_err;
          end
        end
        SCAN: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state      <= IDLE;
              idx        <= '0;
              dec        <= '0;
              dig_sel    <= '0;
              err        <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx     <= idx + IW'(1);
              dec     <= nxt_dec;
              dig_sel <= nxt_sel;
              err     <= nxt_err;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
